limn2600_cache_ctrl: RTL and testbench

//  Arbitrating controller for one limn2600_cache instance. Serves a read-only

---
 rtl/limn2600_cache_ctrl.sv | 170 +++++++++++++++++
 tb/tb_limn2600_cache_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/limn2600_cache_ctrl.sv
// Round-robin arbiter plus valid/tag store wrapped around an external hashed data
// array, turning it into a direct-mapped, write-through, write-allocate cache.
module limn2600_cache_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_ENTRIES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_req,
  input  logic [31:0]           p0_addr,
  output logic                  p0_ack,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [31:0]           p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_ack,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  c_we,
  output logic                  c_find,
  output logic [31:0]           c_addr_in,
  output logic [DATA_WIDTH-1:0] c_data_in,
  output logic [31:0]           c_addr_out,
  input  logic [DATA_WIDTH-1:0] c_data_out,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  flush,
  output logic                  busy
);

  localparam int IW = $clog2(NUM_ENTRIES);

  typedef enum logic [2:0] {
    IDLE, LOOKUP, COMPARE, RD_MEM, WR_MEM, FILL, RESP
  } state_t;

  state_t state, state_nx;

  logic                  port_q;
  logic                  we_q;
  logic [31:0]           addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  rr_last;
  logic                  flush_pend;
  logic [NUM_ENTRIES-1:0] valid;
  logic [31:0]           tag [NUM_ENTRIES];

  logic                  grant;
  logic                  gnt_port;
  logic                  gnt_we;
  logic                  flush_now;
  logic [IW-1:0]         idx;
  logic                  hit;

  // Must stay bit-identical to the hash inside the cache instance.
  function automatic logic [IW-1:0] slot_of(input logic [31:0] a);
    logic [31:0] x;
    x = a;
    x = ((x >> 16) ^ x) * 32'h045d9f3b;
    x = ((x >> 16) ^ x) * 32'h045d9f3b;
    return IW'((x >> 16) ^ x);
  endfunction

  assign idx    = slot_of(addr_q);
  assign hit    = valid[idx] && (tag[idx] == addr_q);
  assign busy   = (state != IDLE);
  assign c_find = 1'b0;

  always_comb begin
    state_nx  = state;
    grant     = 1'b0;
    gnt_port  = 1'b0;
    gnt_we    = 1'b0;
    flush_now = 1'b0;
    p0_ack    = 1'b0;
    p1_ack    = 1'b0;
    p0_rdata  = '0;
    p1_rdata  = '0;
    c_we      = 1'b0;
    c_addr_in = '0;
    c_data_in = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (flush_pend || flush) begin
          flush_now = 1'b1;
        end else if (p0_req || p1_req) begin
          grant    = 1'b1;
          gnt_port = (p0_req && p1_req) ? ~rr_last : p1_req;
          gnt_we   = gnt_port & p1_we;
          state_nx = gnt_we ? WR_MEM : LOOKUP;
        end
      end
      LOOKUP:  state_nx = COMPARE;
      COMPARE: state_nx = hit ? RESP : RD_MEM;
      RD_MEM: begin
        mem_req  = 1'b1;
        mem_addr = addr_q;
        if (mem_ack) state_nx = FILL;
      end
      WR_MEM: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = data_q;
        if (mem_ack) state_nx = FILL;
      end
      FILL: begin
        c_we      = 1'b1;
        c_addr_in = addr_q;
        c_data_in = data_q;
        state_nx  = RESP;
      end
      RESP: begin
        if (port_q) begin
          p1_ack   = 1'b1;
          p1_rdata = we_q ? '0 : data_q;
        end else begin
          p0_ack   = 1'b1;
          p0_rdata = data_q;
        end
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      rr_last    <= 1'b0;
      flush_pend <= 1'b0;
      valid      <= '0;
      c_addr_out <= '0;
    end else begin
      state <= state_nx;
      if (flush_now) begin
        valid      <= '0;
        flush_pend <= 1'b0;
      end else if (flush && state != IDLE) begin
        flush_pend <= 1'b1;
      end
      if (state == FILL) valid[idx] <= 1'b1;
      // Only a genuine conflict moves the round-robin pointer.
      if (grant && p0_req && p1_req) rr_last <= gnt_port;
      if (grant && !gnt_we) c_addr_out <= gnt_port ? p1_addr : p0_addr;
    end
  end

  // Holds write data from grant, then the hit or memory word until RESP.
  always_ff @(posedge clk) begin
    if (grant) begin
      port_q <= gnt_port;
      we_q   <= gnt_we;
      addr_q <= gnt_port ? p1_addr : p0_addr;
      data_q <= gnt_port ? p1_wdata : '0;
    end
    if (state == COMPARE && hit) data_q <= c_data_out;
    if (state == RD_MEM && mem_ack) data_q <= mem_rdata;
    if (state == FILL) tag[idx] <= addr_q;
  end

endmodule

// File: tb/tb_limn2600_cache_ctrl.sv
// Directed plus randomized bench for limn2600_cache_ctrl with cache/memory environment
// models and a reference model of direct-mapped write-through behaviour.
module tb_limn2600_cache_ctrl;
  localparam int DW = 32;
  localparam int NE = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic p0_req, p0_ack, p1_req, p1_we, p1_ack;
  logic [31:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_rdata, p1_rdata, p1_wdata;
  logic c_we, c_find, mem_req, mem_we, mem_ack, flush, busy;
  logic [31:0] c_addr_in, c_addr_out, mem_addr;
  logic [DW-1:0] c_data_in, c_data_out, mem_wdata, mem_rdata;

  limn2600_cache_ctrl #(.DATA_WIDTH(DW), .NUM_ENTRIES(NE)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .c_we(c_we), .c_find(c_find), .c_addr_in(c_addr_in), .c_data_in(c_data_in),
    .c_addr_out(c_addr_out), .c_data_out(c_data_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .flush(flush), .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] h32(input logic [31:0] a);
    logic [31:0] x;
    x = a;
    repeat (2) x = ((x >> 16) ^ x) * 32'h045d9f3b;
    return (x >> 16) ^ x;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'(h32(a) % NE);
  endfunction

  // Power-on contents of external memory.
  function automatic logic [31:0] bg(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'd2654435761) ^ 32'h5A5A0000;
  endfunction

  // Environment: the hashed data array (registered read) and a delayed memory.
  logic [DW-1:0] carr [NE];
  always @(posedge clk) begin
    if (c_we) carr[idx_of(c_addr_in)] <= c_data_in;
    c_data_out <= carr[idx_of(c_addr_out)];
  end

  logic [31:0] mem_store [logic [31:0]];
  int mem_delay = 3;
  int mcnt = 0;
  int mem_reqs = 0;
  int mem_writes = 0;
  logic mreq_prev = 1'b0;
  logic [31:0] last_waddr = '0, last_wdata = '0;
  always @(posedge clk) begin
    mem_ack <= 1'b0;
    mreq_prev <= mem_req;
    if (mem_req && !mreq_prev) mem_reqs++;
    if (mem_req && !mem_ack) begin
      if (mcnt == mem_delay - 1) begin
        mcnt <= 0;
        mem_ack <= 1'b1;
        if (mem_we) begin
          mem_store[mem_addr] = mem_wdata;
          last_waddr <= mem_addr;
          last_wdata <= mem_wdata;
          mem_writes++;
        end else begin
          mem_rdata <= mem_store.exists(mem_addr) ? mem_store[mem_addr] : bg(mem_addr);
        end
      end else begin
        mcnt <= mcnt + 1;
      end
    end else begin
      mcnt <= 0;
    end
  end

  // Reference model: what a direct-mapped write-through cache must do.
  bit          ref_valid [NE];
  logic [31:0] ref_tag   [NE];
  logic [31:0] ref_mem   [logic [31:0]];
  bit          ref_rr_last = 1'b0;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : bg(a);
  endfunction

  function automatic bit ref_hit(input logic [31:0] a);
    return ref_valid[idx_of(a)] && ref_tag[idx_of(a)] == a;
  endfunction

  task automatic ref_apply(input bit we, input logic [31:0] a, input logic [31:0] wd);
    if (we) ref_mem[a] = wd;
    ref_valid[idx_of(a)] = 1'b1;
    ref_tag[idx_of(a)]   = a;
  endtask

  task automatic ref_flush();
    for (int i = 0; i < NE; i++) ref_valid[i] = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  task automatic do_txn(input bit port, input bit we, input logic [31:0] a,
                        input logic [31:0] wd, input int d, input int flush_at,
                        input string nm);
    bit h, got, other;
    int exp_lat, lat, reqs0;
    logic [31:0] exp_data, rd;
    mem_delay = d;
    h = !we && ref_hit(a);
    exp_data = we ? 32'h0 : ref_read(a);
    exp_lat = we ? d + 3 : (h ? 3 : d + 5);
    reqs0 = mem_reqs;
    got = 1'b0; other = 1'b0; lat = -1; rd = '0;
    @(posedge clk); #1;
    if (port) begin
      p1_req = 1'b1; p1_we = we; p1_addr = a; p1_wdata = wd;
    end else begin
      p0_req = 1'b1; p0_addr = a;
    end
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      flush = (n == flush_at);
      if (port ? p0_ack : p1_ack) other = 1'b1;
      if (port ? p1_ack : p0_ack) begin
        got = 1'b1; lat = n; rd = port ? p1_rdata : p0_rdata;
        break;
      end
    end
    flush = 1'b0;
    chk({nm, " ack_seen"}, 32'(got), 32'd1);
    chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, " rdata"}, rd, exp_data);
    chk({nm, " mem_reqs"}, 32'(mem_reqs - reqs0), (we || !h) ? 32'd1 : 32'd0);
    chk({nm, " other_ack"}, 32'(other), 32'd0);
    if (we) begin
      chk({nm, " mem_waddr"}, last_waddr, a);
      chk({nm, " mem_wdata"}, last_wdata, wd);
    end
    @(posedge clk); #1;
    p0_req = 1'b0; p1_req = 1'b0; p1_we = 1'b0;
    if (we || !h) ref_apply(we, a, wd);
    if (flush_at >= 0) ref_flush();
  endtask

  task automatic do_conflict(input logic [31:0] a0, input logic [31:0] a1, input int d,
                             input string nm);
    bit done0, done1;
    int first, exp_first;
    logic [31:0] rd0, rd1, e0, e1;
    mem_delay = d;
    exp_first = ref_rr_last ? 0 : 1;
    e0 = ref_read(a0); e1 = ref_read(a1);
    done0 = 1'b0; done1 = 1'b0; first = -1; rd0 = '0; rd1 = '0;
    @(posedge clk); #1;
    p0_req = 1'b1; p0_addr = a0;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = a1;
    for (int n = 0; n < 300 && !(done0 && done1); n++) begin
      @(negedge clk);
      if (p0_ack && !done0) begin
        done0 = 1'b1; rd0 = p0_rdata;
        if (first < 0) first = 0;
        @(posedge clk); #1; p0_req = 1'b0;
      end else if (p1_ack && !done1) begin
        done1 = 1'b1; rd1 = p1_rdata;
        if (first < 0) first = 1;
        @(posedge clk); #1; p1_req = 1'b0;
      end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    chk({nm, " both_acked"}, 32'(done0 && done1), 32'd1);
    chk({nm, " first_port"}, 32'(first), 32'(exp_first));
    chk({nm, " p0_rdata"}, rd0, e0);
    chk({nm, " p1_rdata"}, rd1, e1);
    ref_rr_last = exp_first[0];
    if (exp_first == 1) begin
      ref_apply(1'b0, a1, '0); ref_apply(1'b0, a0, '0);
    end else begin
      ref_apply(1'b0, a0, '0); ref_apply(1'b0, a1, '0);
    end
  endtask

  initial begin
    logic [31:0] alias_b, pool [8], a;
    bit saw_ack;
    rst = 1'b0; flush = 1'b0;
    p0_req = 1'b0; p0_addr = '0; p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    ref_flush();
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst p0_ack", 32'(p0_ack), 32'd0);
    chk("rst p1_ack", 32'(p1_ack), 32'd0);
    chk("rst c_we", 32'(c_we), 32'd0);
    chk("rst c_addr_out", c_addr_out, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;

    // Miss then hit on the fetch port.
    do_txn(1'b0, 1'b0, 32'h100, '0, 3, -1, "t1 miss");
    do_txn(1'b0, 1'b0, 32'h100, '0, 3, -1, "t1 hit");

    // Round-robin: p1 wins first conflict, p0 the next.
    do_conflict(32'h140, 32'h180, 2, "t2 conflict1");
    do_conflict(32'h140, 32'h180, 2, "t2 conflict2");

    // Write-through with allocate, then a hit on the written word.
    do_txn(1'b1, 1'b1, 32'h200, 32'h12345678, 2, -1, "t3 write");
    do_txn(1'b0, 1'b0, 32'h200, '0, 2, -1, "t3 read_hit");

    // Aliasing slot eviction.
    alias_b = 32'h304;
    for (int k = 1; k < 100000; k++) begin
      alias_b = 32'h300 + 32'(k) * 32'd4;
      if (idx_of(alias_b) == idx_of(32'h300)) break;
    end
    do_txn(1'b0, 1'b0, 32'h300, '0, 1, -1, "t4 first");
    do_txn(1'b1, 1'b0, alias_b, '0, 1, -1, "t4 alias");
    do_txn(1'b0, 1'b0, 32'h300, '0, 1, -1, "t4 reread");

    // Flush arriving mid-miss is deferred, then clears everything.
    do_txn(1'b0, 1'b0, 32'h400, '0, 3, 4, "t5 flush_mid");
    do_txn(1'b0, 1'b0, 32'h100, '0, 3, -1, "t5 after_flush");

    // Asynchronous reset in the middle of a memory read.
    mem_delay = 8;
    @(posedge clk); #1;
    p0_req = 1'b1; p0_addr = 32'h500;
    for (int n = 0; n < 5; n++) @(negedge clk);
    chk("t6 mem_req_before", 32'(mem_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t6 mem_req_async", 32'(mem_req), 32'd0);
    chk("t6 busy_async", 32'(busy), 32'd0);
    p0_req = 1'b0;
    saw_ack = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (p0_ack || p1_ack) saw_ack = 1'b1;
    end
    chk("t6 no_ack", 32'(saw_ack), 32'd0);
    rst = 1'b1;
    ref_flush();
    ref_rr_last = 1'b0;
    do_txn(1'b0, 1'b0, 32'h100, '0, 2, -1, "t6 refill");

    // Randomized traffic over a small address pool with aliasing.
    pool[0] = 32'h100; pool[1] = 32'h200; pool[2] = 32'h300; pool[3] = alias_b;
    pool[4] = 32'h400; pool[5] = 32'h140; pool[6] = 32'h180; pool[7] = 32'h500;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        ref_flush();
      end
      if ($urandom_range(0, 4) == 0) begin
        do_conflict(pool[$urandom_range(0, 7)], pool[$urandom_range(0, 7)],
                    int'($urandom_range(1, 4)), "rnd conflict");
      end else begin
        a = pool[$urandom_range(0, 7)];
        if ($urandom_range(0, 1) == 1)
          do_txn(1'b1, ($urandom_range(0, 2) == 0), a, $urandom,
                 int'($urandom_range(1, 4)), -1, "rnd p1");
        else
          do_txn(1'b0, 1'b0, a, '0, int'($urandom_range(1, 4)), -1, "rnd p0");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
